// File: rtl/protocol_pkg.sv
// -----------------------------------------------------------------------------
// protocol_pkg
//
// MCU command-stream protocol: opcode encoding, header field layout and the
// payload length of each opcode.
//
// Header byte: [7:5] opcode, [4:0] index (voice, or envelope for SET_ENV).
// Payload bytes follow the header, most significant byte first.
// -----------------------------------------------------------------------------
package protocol_pkg;

  localparam int OPCODE_W   = 3;
  localparam int OPCODE_LSB = 5;
  localparam int INDEX_W    = 5;
  localparam int INDEX_LSB  = 0;

  // Wide enough for the longest payload (SET_ENV, 8 bytes).
  localparam int COUNT_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_SET_FREQ  = 3'd0,
    OP_SET_AMP   = 3'd1,
    OP_SET_SHAPE = 3'd2,
    OP_NOTE_ON   = 3'd3,
    OP_NOTE_OFF  = 3'd4,
    OP_SET_ENV   = 3'd5,
    OP_NOP       = 3'd6,
    OP_RESERVED  = 3'd7
  } opcode_t;

  // Number of payload bytes that follow a header with this opcode.
  function automatic logic [COUNT_W-1:0] payload_len(opcode_t op, int width);
    logic [COUNT_W-1:0] len;
    len = '0;
    case (op)
      OP_SET_FREQ:  len = COUNT_W'(4);
      OP_SET_AMP:   len = COUNT_W'(width / 8);
      OP_SET_SHAPE: len = COUNT_W'(1);
      OP_SET_ENV:   len = COUNT_W'(8);
      default:      len = '0;
    endcase
    return len;
  endfunction

endpackage : protocol_pkg

// File: rtl/voice_param_decoder_pkg.sv
// -----------------------------------------------------------------------------
// voice_param_decoder_pkg
//
// Oscillator-side types shared by the decoder and the oscillator bank:
// waveform selection, envelope table entry, envelope table length and the
// position of the envelope-reset flag inside a voice command byte.
// -----------------------------------------------------------------------------
package voice_param_decoder_pkg;

  // Number of entries in the shared envelope table.
  localparam int ENVELOPE_LEN = 8;

  // Bit of a voice command byte that asks the oscillator to restart its envelope.
  localparam int ENVELOPE_RESET_BIT = 0;

  typedef enum logic [1:0] {
    SIN      = 2'd0,
    SQUARE   = 2'd1,
    SAW      = 2'd2,
    TRIANGLE = 2'd3
  } wave_shape;

  // One envelope segment: gain and how many samples it lasts (never 0).
  typedef struct packed {
    logic [31:0] gain;
    logic [31:0] duration;
  } envelope_t;

endpackage : voice_param_decoder_pkg

// File: rtl/voice_param_decoder_if.sv
// -----------------------------------------------------------------------------
// voice_param_decoder_if
//
// Byte-wide valid/ready stream from the MCU serial receiver into the decoder.
//   in_data  : command byte
//   in_valid : in_data holds a byte
//   in_ready : the sink takes the byte on a cycle where in_valid && in_ready
// Modports: master = byte source, slave = decoder.
// -----------------------------------------------------------------------------
interface voice_param_decoder_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface : voice_param_decoder_if

// File: rtl/voice_param_decoder_payload_shift_reg.sv
// -----------------------------------------------------------------------------
// payload_shift_reg
//
// 64-bit byte-wide shift register that assembles a command payload. Bytes
// arrive MSB first, so after k bytes the payload sits in word[8k-1:0].
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the word (start of a new frame); wins over shift_en
//   shift_en  : shift byte_in into the low byte
//   byte_in   : payload byte
//   word      : assembled payload
// -----------------------------------------------------------------------------
module payload_shift_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [63:0] word
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make results depend on process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {word[55:0], byte_in};
    end
  end

endmodule : payload_shift_reg

// File: rtl/voice_param_decoder.sv
// -----------------------------------------------------------------------------
// voice_param_decoder
//
// Decodes the MCU command byte stream into per-voice oscillator controls and
// a shared envelope table. A frame (header + payload) is assembled first and
// then committed to the register file in a single cycle, so the oscillator
// bank never sees a half-written parameter.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   sample_tick  : one-cycle strobe at the oscillator sample boundary
//   bus          : command byte stream (slave side)
//   enable       : per-voice oscillator enable
//   freq         : per-voice 32-bit fixed-point frequency
//   amplitude    : per-voice amplitude, WIDTH bits
//   shape        : per-voice waveform
//   cmds         : per-voice command byte; only ENVELOPE_RESET_BIT is used
//   envelopes    : shared envelope table
//   err_count    : saturating count of malformed or aborted frames
//
// Build option
//   DECODER_TIMEOUT_EN : when defined, a frame whose payload stalls for
//                        TIMEOUT_CYCLES cycles is dropped and counted as an
//                        error. Undefined: the decoder waits forever.
// -----------------------------------------------------------------------------
module voice_param_decoder
  import voice_param_decoder_pkg::*;
  import protocol_pkg::*;
#(
  parameter int VOICES         = 8,
  parameter int WIDTH          = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  voice_param_decoder_if.slave          bus,
  output logic [VOICES-1:0]             enable,
  output logic [VOICES-1:0][31:0]       freq,
  output logic [VOICES-1:0][WIDTH-1:0]  amplitude,
  output wave_shape                     shape [VOICES],
  output logic [VOICES-1:0][7:0]        cmds,
  output envelope_t                     envelopes [ENVELOPE_LEN],
  output logic [7:0]                    err_count
);

  typedef enum logic [1:0] {
    S_HEADER,
    S_PAYLOAD,
    S_COMMIT
  } state_t;

  state_t               state;
  state_t               state_next;
  opcode_t              op_q;
  logic [INDEX_W-1:0]   idx_q;
  logic [COUNT_W-1:0]   count_q;
  logic [63:0]          word;
  logic [VOICES-1:0]    env_reset_q;

  logic                 accept;
  opcode_t              hdr_op;
  logic [COUNT_W-1:0]   hdr_len;
  logic                 stall_hit;
  logic                 commit_err;
  logic                 commit_write;

  // in_ready depends only on the state register, never on in_data/in_valid.
  assign bus.in_ready = (state != S_COMMIT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign hdr_op       = opcode_t'(bus.in_data[OPCODE_LSB +: OPCODE_W]);
  assign hdr_len      = payload_len(hdr_op, WIDTH);

  // ---------------------------------------------------------------------------
  // Payload stall watchdog
  // ---------------------------------------------------------------------------
`ifdef DECODER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q;

  // Counts idle cycles while waiting for payload; any accepted byte restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state != S_PAYLOAD || accept) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_hit = (state == S_PAYLOAD) && !accept &&
                     (int'(stall_q) == TIMEOUT_CYCLES - 1);
`else
  assign stall_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HEADER;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_HEADER: begin
        if (accept) begin
          state_next = (hdr_len != '0) ? S_PAYLOAD : S_COMMIT;
        end
      end
      S_PAYLOAD: begin
        if (accept && count_q == COUNT_W'(1)) begin
          state_next = S_COMMIT;
        end else if (stall_hit) begin
          state_next = S_HEADER;
        end
      end
      S_COMMIT: state_next = S_HEADER;
      default:  state_next = S_HEADER;
    endcase
  end

  // Header fields and remaining payload count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_NOP;
      idx_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      if (state == S_HEADER) begin
        op_q    <= hdr_op;
        idx_q   <= bus.in_data[INDEX_LSB +: INDEX_W];
        count_q <= hdr_len;
      end else begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  payload_shift_reg u_payload (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept && state == S_HEADER),
    .shift_en (accept && state == S_PAYLOAD),
    .byte_in  (bus.in_data),
    .word     (word)
  );

  // ---------------------------------------------------------------------------
  // Commit decision: out-of-range targets and the reserved opcode are errors;
  // their payload has already been consumed, only the write is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    commit_err = 1'b0;
    if (state == S_COMMIT) begin
      case (op_q)
        OP_SET_ENV:  commit_err = !(int'(idx_q) < ENVELOPE_LEN);
        OP_NOP:      commit_err = 1'b0;
        OP_RESERVED: commit_err = 1'b1;
        default:     commit_err = !(int'(idx_q) < VOICES);
      endcase
    end
  end

  assign commit_write = (state == S_COMMIT) && !commit_err;

  // ---------------------------------------------------------------------------
  // Voice register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable    <= '0;
      freq      <= '0;
      amplitude <= '0;
      for (int v = 0; v < VOICES; v++) begin
        shape[v] <= SIN;
      end
    end else if (commit_write) begin
      for (int v = 0; v < VOICES; v++) begin
        if (int'(idx_q) == v) begin
          case (op_q)
            OP_SET_FREQ:  freq[v]      <= word[31:0];
            OP_SET_AMP:   amplitude[v] <= word[WIDTH-1:0];
            OP_SET_SHAPE: shape[v]     <= wave_shape'(word[1:0]);
            OP_NOTE_ON:   enable[v]    <= 1'b1;
            OP_NOTE_OFF:  enable[v]    <= 1'b0;
            default:      ;
          endcase
        end
      end
    end
  end

  // Envelope-reset request. A NOTE_ON commit sets it and takes priority over
  // a tick in the same cycle, so the oscillator is guaranteed to see the
  // request on at least one later sample boundary before it is withdrawn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_reset_q <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (commit_write && op_q == OP_NOTE_ON && int'(idx_q) == v) begin
          env_reset_q[v] <= 1'b1;
        end else if (sample_tick) begin
          env_reset_q[v] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    cmds = '0;
    for (int v = 0; v < VOICES; v++) begin
      cmds[v][ENVELOPE_RESET_BIT] = env_reset_q[v];
    end
  end

  // ---------------------------------------------------------------------------
  // Envelope table. Duration 0 is stored as 1 so the envelope generator can
  // divide by it unconditionally.
  // ---------------------------------------------------------------------------
  // NOTE: the table is a small register array read in parallel by the
  // oscillators, so it is reset like any other flop; a RAM macro would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ENVELOPE_LEN; e++) begin
        envelopes[e] <= '{gain: 32'd0, duration: 32'd1};
      end
    end else if (commit_write && op_q == OP_SET_ENV) begin
      for (int e = 0; e < ENVELOPE_LEN; e++) begin
        if (int'(idx_q) == e) begin
          envelopes[e].gain     <= word[63:32];
          envelopes[e].duration <= (word[31:0] == 32'd0) ? 32'd1 : word[31:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter (saturating)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if ((commit_err || stall_hit) && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule : voice_param_decoder

// File: tb/tb_voice_param_decoder.sv
// -----------------------------------------------------------------------------
// tb_voice_param_decoder
//
// Frame vectors come from a table; each frame pushes its expected result onto
// a scoreboard queue before its bytes are driven, and a monitor pops and
// compares one entry on the cycle after every COMMIT. Hand-written sequences
// cover envelope-reset timing, asynchronous reset mid-frame, payload stalls
// and err_count saturation.
// -----------------------------------------------------------------------------
module tb_voice_param_decoder;
  import voice_param_decoder_pkg::*;

  localparam int VOICES         = 8;
  localparam int WIDTH          = 24;
  localparam int TIMEOUT_CYCLES = 16;

  logic clk = 1'b0;
  logic rst;
  logic sample_tick;

  voice_param_decoder_if bus ();

  logic [VOICES-1:0]            enable;
  logic [VOICES-1:0][31:0]      freq;
  logic [VOICES-1:0][WIDTH-1:0] amplitude;
  wave_shape                    shape [VOICES];
  logic [VOICES-1:0][7:0]       cmds;
  envelope_t                    envelopes [ENVELOPE_LEN];
  logic [7:0]                   err_count;

  voice_param_decoder #(
    .VOICES         (VOICES),
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .bus         (bus),
    .enable      (enable),
    .freq        (freq),
    .amplitude   (amplitude),
    .shape       (shape),
    .cmds        (cmds),
    .envelopes   (envelopes),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef enum int {F_NONE, F_FREQ, F_AMP, F_SHAPE, F_ENABLE, F_ENV} field_t;

  typedef struct {
    string       name;
    field_t      field;
    int          index;
    logic [63:0] value;
    logic [7:0]  err;
  } exp_t;

  typedef struct {
    exp_t        e;
    logic [71:0] bytes;   // left-aligned, first byte in [71:64]
    int          n;
  } vec_t;

  exp_t sb_q [$];
  vec_t vecs [$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [7:0] ENV_BIT = 8'(1 << ENVELOPE_RESET_BIT);

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] actual_field(input field_t f, input int i);
    case (f)
      F_FREQ:   return 64'(freq[i]);
      F_AMP:    return 64'(amplitude[i]);
      F_SHAPE:  return 64'(shape[i]);
      F_ENABLE: return 64'(enable[i]);
      F_ENV:    return {envelopes[i].gain, envelopes[i].duration};
      default:  return 64'd0;
    endcase
  endfunction

  // Monitor: outputs settle on the edge that ends COMMIT, so compare at the
  // negedge following the one where in_ready was seen low.
  logic prev_commit = 1'b0;
  always @(negedge clk) begin
    if (prev_commit) begin
      if (sb_q.size() == 0) begin
        check("unexpected_commit", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.field != F_NONE) check(e.name, actual_field(e.field, e.index), e.value);
        check({e.name, "_err"}, 64'(err_count), 64'(e.err));
      end
    end
    prev_commit = (bus.in_ready === 1'b0) && !rst;
  end

  task automatic add_vec(input string name, input logic [71:0] bytes, input int n,
                         input field_t f, input int idx, input logic [63:0] value,
                         input logic [7:0] err);
    vec_t v;
    v.e.name  = name;
    v.e.field = f;
    v.e.index = idx;
    v.e.value = value;
    v.e.err   = err;
    v.bytes   = bytes;
    v.n       = n;
    vecs.push_back(v);
  endtask

  function automatic exp_t mk_exp(input string name, input field_t f, input int idx,
                                  input logic [63:0] value, input logic [7:0] err);
    exp_t e;
    e.name  = name;
    e.field = f;
    e.index = idx;
    e.value = value;
    e.err   = err;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        check("ready_timeout", 64'(guard), 64'd0);
        return;
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
  endtask

  task automatic send_frame(input logic [71:0] bytes, input int n, input bit gaps,
                            input bit push, input exp_t e);
    if (push) sb_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      send_byte(bytes[71 - 8*k -: 8], gaps);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    int   model_err;
    none = mk_exp("none", F_NONE, 0, 64'd0, 8'd0);

    rst          = 1'b1;
    sample_tick  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);

    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_err",       64'(err_count), 64'd0);
    check("rst_enable",    64'(enable), 64'd0);
    check("rst_shape5",    64'(shape[5]), 64'(SIN));
    check("rst_env3",      {envelopes[3].gain, envelopes[3].duration}, 64'h0000_0000_0000_0001);
    rst = 1'b0;
    @(negedge clk);

    // ------------------------------------------------------------- table ---
    add_vec("freq_v1",      72'h01_00_01_B8_00_00_00_00_00, 5, F_FREQ,   1, 64'h0001_B800, 8'd0);
    add_vec("amp_v3",       72'h23_12_34_56_00_00_00_00_00, 4, F_AMP,    3, 64'h12_3456,   8'd0);
    add_vec("shape_v3",     72'h43_02_00_00_00_00_00_00_00, 2, F_SHAPE,  3, 64'(SAW),      8'd0);
    add_vec("note_on_v2",   72'h62_00_00_00_00_00_00_00_00, 1, F_ENABLE, 2, 64'd1,         8'd0);
    add_vec("env0_dur0",    72'hA0_00_01_00_00_00_00_00_00, 9, F_ENV,    0, 64'h0001_0000_0000_0001, 8'd0);
    add_vec("env1",         72'hA1_DE_AD_BE_EF_00_00_00_05, 9, F_ENV,    1, 64'hDEAD_BEEF_0000_0005, 8'd0);
    add_vec("amp_bad_v9",   72'h29_11_22_33_00_00_00_00_00, 4, F_AMP,    1, 64'd0,         8'd1);
    add_vec("nop_after_bad",72'hC0_00_00_00_00_00_00_00_00, 1, F_FREQ,   1, 64'h0001_B800, 8'd1);
    add_vec("note_off_v2",  72'h82_00_00_00_00_00_00_00_00, 1, F_ENABLE, 2, 64'd0,         8'd1);
    add_vec("amp_kept_v3",  72'hC3_00_00_00_00_00_00_00_00, 1, F_AMP,    3, 64'h12_3456,   8'd1);
    add_vec("reserved",     72'hE0_00_00_00_00_00_00_00_00, 1, F_NONE,   0, 64'd0,         8'd2);
    add_vec("env_bad_idx9", 72'hA9_11_11_11_11_22_22_22_22, 9, F_ENV,    1, 64'hDEAD_BEEF_0000_0005, 8'd3);
    add_vec("freq_v7",      72'h07_FF_FF_FF_FF_00_00_00_00, 5, F_FREQ,   7, 64'hFFFF_FFFF, 8'd3);
    add_vec("freq_bad_v31", 72'h1F_01_02_03_04_00_00_00_00, 5, F_FREQ,   7, 64'hFFFF_FFFF, 8'd4);
    add_vec("note_on_v7",   72'h67_00_00_00_00_00_00_00_00, 1, F_ENABLE, 7, 64'd1,         8'd4);
    add_vec("freq_v0_kept", 72'hC0_00_00_00_00_00_00_00_00, 1, F_FREQ,   0, 64'd0,         8'd4);
    add_vec("shape_sq_v0",  72'h40_01_00_00_00_00_00_00_00, 2, F_SHAPE,  0, 64'(SQUARE),   8'd4);

    foreach (vecs[i]) begin
      send_frame(vecs[i].bytes, vecs[i].n, 1'b1, 1'b1, vecs[i].e);
    end
    repeat (3) @(negedge clk);

    // ---------------------------------------------- envelope-reset timing ---
    check("env_rst_v2_held", 64'(cmds[2]), 64'(ENV_BIT));
    check("env_rst_v7_held", 64'(cmds[7]), 64'(ENV_BIT));
    check("cmds_v3_zero",    64'(cmds[3]), 64'd0);
    sample_tick = 1'b1;
    check("env_rst_v2_before_edge", 64'(cmds[2]), 64'(ENV_BIT));
    @(negedge clk);
    sample_tick = 1'b0;
    check("env_rst_v2_cleared", 64'(cmds[2]), 64'd0);
    check("env_rst_v7_cleared", 64'(cmds[7]), 64'd0);

    // Tick coinciding with COMMIT must not clear the new request.
    send_frame(72'h65_00_00_00_00_00_00_00_00, 1, 1'b0, 1'b1,
               mk_exp("note_on_v5", F_ENABLE, 5, 64'd1, 8'd4));
    check("commit_ready_low", 64'(bus.in_ready), 64'd0);
    check("no_early_update",  64'(enable[5]), 64'd0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("ready_back_high", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("tick_in_commit_ignored", 64'(cmds[5]), 64'(ENV_BIT));
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("env_rst_v5_cleared", 64'(cmds[5]), 64'd0);

    // --------------------------------------------------- reset mid-frame ---
    send_frame(72'h00_AA_BB_00_00_00_00_00_00, 3, 1'b0, 1'b0, none);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_enable",   64'(enable), 64'd0);
    check("mid_rst_freq1",    64'(freq[1]), 64'd0);
    check("mid_rst_freq7",    64'(freq[7]), 64'd0);
    check("mid_rst_amp3",     64'(amplitude[3]), 64'd0);
    check("mid_rst_shape3",   64'(shape[3]), 64'(SIN));
    check("mid_rst_cmds",     64'(cmds), 64'd0);
    check("mid_rst_err",      64'(err_count), 64'd0);
    check("mid_rst_env1",     {envelopes[1].gain, envelopes[1].duration}, 64'h0000_0000_0000_0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(72'h00_11_22_33_44_00_00_00_00, 5, 1'b1, 1'b1,
               mk_exp("freq_v0_after_rst", F_FREQ, 0, 64'h1122_3344, 8'd0));

    // ----------------------------------------------------- payload stall ---
`ifdef DECODER_TIMEOUT_EN
    send_frame(72'h04_0A_00_00_00_00_00_00_00, 2, 1'b0, 1'b0, none);
    repeat (TIMEOUT_CYCLES + 1) @(negedge clk);
    check("timeout_err",      64'(err_count), 64'd1);
    check("timeout_in_ready", 64'(bus.in_ready), 64'd1);
    send_frame(72'hC0_00_00_00_00_00_00_00_00, 1, 1'b0, 1'b1,
               mk_exp("after_timeout_nop", F_FREQ, 4, 64'd0, 8'd1));
    model_err = 1;
`else
    sb_q.push_back(mk_exp("freq_v4_stalled", F_FREQ, 4, 64'h0A0B_0C0D, 8'd0));
    send_byte(8'h04, 1'b0);
    send_byte(8'h0A, 1'b0);
    repeat (TIMEOUT_CYCLES + 4) @(negedge clk);
    check("stall_still_waiting", 64'(bus.in_ready), 64'd1);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h0D, 1'b0);
    model_err = 0;
`endif

    // ------------------------------------------------- err_count saturation ---
    for (int i = 0; i < 257; i++) begin
      model_err = (model_err < 255) ? model_err + 1 : 255;
      send_frame(72'hE0_00_00_00_00_00_00_00_00, 1, 1'b0, 1'b1,
                 mk_exp("err_sat", F_NONE, 0, 64'd0, 8'(model_err)));
    end
    repeat (3) @(negedge clk);
    check("err_saturated",      64'(err_count), 64'd255);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_voice_param_decoder

// File: doc/voice_param_decoder.md
# voice_param_decoder

Byte-stream command decoder that drives per-voice oscillator control inputs: frequency, amplitude, shape, enable, command bits, and a shared envelope table. It sits between the MCU-facing serial receiver (byte valid/ready stream) and the oscillator bank. It assembles each command frame, then commits it atomically into the voice register file. It converts NOTE_ON into an envelope-reset command held until the next sample tick.

## Interface
- VOICES, 8, number of oscillator voices; voice index is header bits [4:0], so VOICES ≤ 32
- WIDTH, 24, amplitude width; must be a multiple of 8
- TIMEOUT_CYCLES, 1024, payload stall limit; used only with DECODER_TIMEOUT_EN
- clk  in  1  system clock; the single clock of the block
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  command byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  byte accepted on the cycle where in_valid && in_ready
- sample_tick  in  1  one-cycle strobe marking the oscillator sample boundary
- enable  out  VOICES  per-voice oscillator enable
- freq  out  VOICES×32  per-voice fixed-point frequency
- amplitude  out  VOICES×WIDTH  per-voice amplitude
- shape  out  VOICES×wave_shape  per-voice waveform
- cmds  out  VOICES×8  per-voice command bits; only ENVELOPE_RESET_BIT is driven, all other bits are 0
- envelopes  out  ENVELOPE_LEN×envelope_t  shared envelope table
- err_count  out  8  saturating count of malformed or aborted frames

## Operation
- Header byte layout: bits [7:5] are the opcode; bits [4:0] are the index (voice index, or envelope index for SET_ENV). Payload bytes follow, MSB first.
- Opcodes and payload lengths:
  - 0 SET_FREQ: 4 bytes
  - 1 SET_AMP: WIDTH/8 bytes
  - 2 SET_SHAPE: 1 byte; low bits are the wave_shape value
  - 3 NOTE_ON: 0 bytes
  - 4 NOTE_OFF: 0 bytes
  - 5 SET_ENV: 8 bytes; gain[31:0] first, then duration[31:0]
  - 6 NOP: 0 bytes
  - 7 reserved: 0 bytes; counts as an error
- FSM states:
  - HEADER: accept a byte; latch opcode and index; load the remaining count; go to PAYLOAD if the count > 0, else COMMIT.
  - PAYLOAD: shift in bytes; decrement the count on each accepted byte; go to COMMIT after the last byte.
  - COMMIT: one cycle with in_ready=0; write the target registers; return to HEADER.
- Commit actions:
  - NOTE_ON: enable[v]=1 and set cmds[v][ENVELOPE_RESET_BIT].
  - NOTE_OFF: enable[v]=0; freq, amplitude and shape are kept.
- Invalid index (voice ≥ VOICES, or envelope index ≥ ENVELOPE_LEN): the payload is still consumed, the write is suppressed, and err_count increments.
- SET_ENV with duration 0 is stored as duration 1, so the envelope never divides by zero.
- The envelope-reset bit stays set until the first sample_tick strictly after the commit cycle, then clears on the following clock edge.
  - If a sample_tick coincides with COMMIT, that tick does not clear the bit.
- err_count saturates at 255.

## Timing
- in_ready is 1 in HEADER and PAYLOAD and 0 only in COMMIT.
- Header accepted at cycle N with 0 payload: COMMIT at N+1; outputs change at N+2.
- With k payload bytes: COMMIT is the cycle after the k-th accepted byte; outputs change one cycle later.
- Back-to-back frames lose exactly one cycle (COMMIT) between frames.
- Gaps in in_valid are allowed anywhere and do not affect the result.
- Reset values:
  - in_ready=1, enable=0, freq=0, amplitude=0, shape=SIN, cmds=0, err_count=0.
  - Every envelope entry: gain=0, duration=1.
  - FSM in HEADER.
- rst asserted mid-frame discards the partial frame; all outputs return to their reset values immediately (asynchronous reset).
- Outputs are registered; there is no combinational path from in_data to any output.

## Configuration
- DECODER_TIMEOUT_EN defined:
  - A stall counter in PAYLOAD resets on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: abort to HEADER, suppress the write, and increment err_count.
- DECODER_TIMEOUT_EN undefined: PAYLOAD waits indefinitely; no counter logic is generated.

## Structure
- protocol_pkg holds:
  - the opcode enum;
  - header field widths and positions;
  - the function payload_len(opcode, WIDTH).
- envelope_t, wave_shape, ENVELOPE_LEN and ENVELOPE_RESET_BIT stay in their existing packages and headers.
- One sub-module, payload_shift_reg: a 64-bit byte-wide shift register with a load/clear input and an assembled-word output, shared by all opcodes.

## Test plan
- Send 0x01,0x00,0x01,0xB8,0x00 (SET_FREQ voice 1): freq[1]=0x0001B800 two cycles after the last byte; all other voices unchanged.
- Send NOTE_ON 0x62 (voice 2) with no sample_tick: enable[2]=1 and cmds[2][ENVELOPE_RESET_BIT]=1, held. Pulse sample_tick: the bit clears one cycle after the tick.
- Send SET_ENV index 0 with gain 0x10000 and duration 0: envelopes[0].gain=0x10000 and envelopes[0].duration=1.
- Send SET_AMP to voice 9 (VOICES=8) with 3 payload bytes, then NOP: no amplitude changes, err_count=1, and the NOP is decoded normally.
- Assert rst after 2 of 4 SET_FREQ payload bytes: outputs return to reset values. A following complete frame decodes correctly.
- With DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send a header plus 1 payload byte, then idle 16 cycles. FSM returns to HEADER, err_count=1, and the next header is accepted.
